// File: rtl/hash_engine.sv
// Iterative byte-stream hash core: absorbs one byte per valid/ready handshake,
// applies NUM_ROUNDS rounds per byte (one per clock) and hands off the 4-lane state.
module hash_engine #(
    parameter int unsigned         WIDTH      = 8,
    parameter int unsigned         NUM_ROUNDS = 6,
    parameter int unsigned         CH_LAST    = 2,
    parameter int unsigned         MAJ_LAST   = 4,
    parameter logic [4*WIDTH-1:0]  IV         = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   digest,
    output logic [15:0]          byte_count
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_t;

    localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

    fsm_t               fsm;
    logic [4*WIDTH-1:0] state_q;
    logic [6:0]         round_cnt;
    logic [7:0]         byte_q;
    logic               last_q;

    logic [WIDTH-1:0]   lane_a, lane_b, lane_c, lane_d;
    logic [WIDTH-1:0]   mix, sum;
    logic [31:0]        round_idx;
    logic [4*WIDTH-1:0] next_state;

    // Shifting by WIDTH yields zero, so a rotate amount of 0 degenerates cleanly to x.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned s);
        rotl = (x << s) | (x >> (WIDTH - s));
    endfunction

    assign round_idx = 32'(round_cnt);

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        {lane_d, lane_c, lane_b, lane_a} = state_q;
        if (round_idx <= CH_LAST)
            mix = (lane_c & lane_b) | (~lane_b & lane_d);
        else if (round_idx <= MAJ_LAST)
            mix = (lane_c & lane_b) | (lane_c & lane_d) | (lane_b & lane_d);
        else
            mix = lane_b ^ lane_c ^ lane_d;
        sum        = lane_a + WIDTH'(byte_q) + mix;
        next_state = {lane_c, lane_b, rotl(sum, round_idx % WIDTH), lane_d};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            state_q    <= IV;
            round_cnt  <= '0;
            byte_q     <= '0;
            last_q     <= 1'b0;
            byte_count <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        byte_q    <= in_byte;
                        last_q    <= in_last;
                        round_cnt <= '0;
                        if (byte_count != 16'hFFFF)
                            byte_count <= byte_count + 16'd1;
                        in_ready  <= 1'b0;
                        fsm       <= BUSY;
                    end
                end
                BUSY: begin
                    state_q   <= next_state;
                    round_cnt <= round_cnt + 7'd1;
                    if (round_cnt == LAST_ROUND) begin
                        if (last_q) begin
                            out_valid <= 1'b1;
                            fsm       <= DONE;
                        end else begin
                            in_ready  <= 1'b1;
                            fsm       <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IV;
                        byte_count <= '0;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        fsm        <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Digest is the live state; consumers qualify it with out_valid.
    assign digest = state_q;

endmodule

// File: tb/tb_hash_engine.sv
// Self-checking bench for hash_engine: five differently parametrised instances
// driven by directed and random messages, checked against a lane-level model.
module tb_hash_engine;

    localparam int NDUT = 5;
    localparam int          CW   [NDUT] = '{8, 8, 8, 16, 8};
    localparam int          CN   [NDUT] = '{1, 2, 6, 20, 12};
    localparam int          CCH  [NDUT] = '{2, 2, 2, 5, 3};
    localparam int          CMAJ [NDUT] = '{4, 4, 4, 11, 7};
    localparam logic [63:0] CIV  [NDUT] = '{64'h0, 64'h0, 64'h0,
                                            64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF};
    localparam int BOUND = 400;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic [7:0]  in_byte   [NDUT];
    logic        in_last   [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic [63:0] dg        [NDUT];
    logic [15:0] bc        [NDUT];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [4*CW[g]-1:0] d_w;
        hash_engine #(
            .WIDTH      (CW[g]),
            .NUM_ROUNDS (CN[g]),
            .CH_LAST    (CCH[g]),
            .MAJ_LAST   (CMAJ[g]),
            .IV         (CIV[g][4*CW[g]-1:0])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_byte    (in_byte[g]),
            .in_last    (in_last[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .digest     (d_w),
            .byte_count (bc[g])
        );
        assign dg[g] = 64'(d_w);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane-level model: lanes a..d as plain integers, one round per loop step.
    function automatic logic [63:0] ref_hash(input int k, input bq_t msg);
        int w = CW[k];
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned a, b, c, d, mix, m, rot, na, nb, nc, nd;
        int s;
        a = CIV[k] & mask;
        b = (CIV[k] >> w) & mask;
        c = (CIV[k] >> (2 * w)) & mask;
        d = (CIV[k] >> (3 * w)) & mask;
        foreach (msg[i]) begin
            for (int r = 0; r < CN[k]; r++) begin
                if (r <= CCH[k])       mix = (c & b) | (~b & d);
                else if (r <= CMAJ[k]) mix = (c & b) | (c & d) | (b & d);
                else                   mix = b ^ c ^ d;
                m   = (a + 64'(msg[i]) + (mix & mask)) & mask;
                s   = r % w;
                rot = ((m << s) | (m >> (w - s))) & mask;
                na = d; nb = rot; nc = b; nd = c;
                a = na; b = nb; c = nc; d = nd;
            end
        end
        return (d << (3 * w)) | (c << (2 * w)) | (b << w) | a;
    endfunction

    task automatic send_byte(input int k, input logic [7:0] b, input logic last,
                             input int stall, input bit noise);
        int n = 0;
        repeat (stall) @(negedge clk);
        @(negedge clk);
        in_byte[k]  = b;
        in_last[k]  = last;
        in_valid[k] = 1'b1;
        if (noise) out_ready[k] = last ? 1'b0 : 1'($urandom_range(0, 1));
        while (!in_ready[k] && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("accept_timeout", 64'(in_ready[k]), 64'd1);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        if (noise && last) out_ready[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        int n = 0;
        while (!out_valid[k] && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 64'(out_valid[k]), 64'd1);
    endtask

    // Waits for the digest, holds it for `stall` cycles, then hands it off.
    task automatic recv_digest(input int k, input logic [63:0] exp, input int exp_cnt, input int stall);
        wait_valid(k);
        check("digest", dg[k], exp);
        check("byte_count", 64'(bc[k]), 64'(exp_cnt));
        repeat (stall) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid[k]), 64'd1);
            check("hold_digest", dg[k], exp);
            check("hold_in_ready", 64'(in_ready[k]), 64'd0);
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        @(negedge clk);
        check("handoff_out_valid", 64'(out_valid[k]), 64'd0);
        check("handoff_in_ready", 64'(in_ready[k]), 64'd1);
        check("handoff_iv", dg[k], CIV[k]);
        check("handoff_count", 64'(bc[k]), 64'd0);
    endtask

    // Counts negedges from acceptance until out_valid (last) or in_ready (not last) rises.
    task automatic latency(input int k, input logic [7:0] b, input logic last, output int cycles);
        send_byte(k, b, last, 0, 1'b0);
        cycles = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (last ? out_valid[k] : in_ready[k]) break;
            cycles++;
        end
    endtask

    task automatic run_msg(input int k, input int len, input int stall);
        bq_t msg;
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
        foreach (msg[i]) send_byte(k, msg[i], i == len - 1, $urandom_range(0, stall), 1'b1);
        recv_digest(k, ref_hash(k, msg), (len > 65535) ? 65535 : len, $urandom_range(0, stall));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        bq_t  msg;
        logic [63:0] exp;

        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0; in_byte[k] = '0; in_last[k] = 1'b0; out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("reset_in_ready", 64'(in_ready[k]), 64'd0);
            check("reset_digest", dg[k], CIV[k]);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("post_reset_in_ready", 64'(in_ready[k]), 64'd1);
            check("post_reset_out_valid", 64'(out_valid[k]), 64'd0);
            check("post_reset_count", 64'(bc[k]), 64'd0);
        end

        // Single-byte latency and digest with one and two rounds.
        latency(0, 8'h01, 1'b1, cyc);
        check("latency_r1", 64'(cyc), 64'd1);
        recv_digest(0, 64'h0000_0100, 1, 0);
        latency(1, 8'h01, 1'b1, cyc);
        check("latency_r2", 64'(cyc), 64'd2);
        recv_digest(1, 64'h0001_0200, 1, 0);

        // Non-last byte: in_ready low for exactly NUM_ROUNDS cycles, then finish the message.
        latency(1, 8'h37, 1'b0, cyc);
        check("in_ready_low_r2", 64'(cyc), 64'd2);
        send_byte(1, 8'h01, 1'b1, 0, 1'b0);
        msg = {8'h37, 8'h01};
        recv_digest(1, ref_hash(1, msg), 2, 0);

        // Zero byte with defaults, digest held for 10 cycles without out_ready.
        send_byte(2, 8'h00, 1'b1, 0, 1'b0);
        recv_digest(2, 64'h0, 1, 10);

        // Back-to-back messages with out_ready held high: IV reload and count restart.
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'($urandom_range(0, 255)));
        exp = ref_hash(4, msg);
        out_ready[4] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            in_byte[4] = msg[0]; in_last[4] = 1'b0; in_valid[4] = 1'b1;
            check("b2b_ready_for_first", 64'(in_ready[4]), 64'd1);
            @(posedge clk);
            #1;
            in_valid[4] = 1'b0;
            check("b2b_count_restart", 64'(bc[4]), 64'd1);
            for (int i = 1; i < 5; i++) send_byte(4, msg[i], i == 4, $urandom_range(0, 2), 1'b0);
            wait_valid(4);
            check("b2b_digest", dg[4], exp);
            check("b2b_count", 64'(bc[4]), 64'd5);
            @(negedge clk);
            check("b2b_handoff_1cyc", 64'(out_valid[4]), 64'd0);
            check("b2b_in_ready", 64'(in_ready[4]), 64'd1);
        end
        out_ready[4] = 1'b0;

        // Asynchronous reset mid-BUSY (and with a pending digest) takes effect immediately.
        send_byte(0, 8'hA5, 1'b1, 0, 1'b0);
        send_byte(4, 8'h3C, 1'b0, 0, 1'b0);
        send_byte(2, 8'h5A, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("midrst_in_ready", 64'(in_ready[k]), 64'd0);
            check("midrst_out_valid", 64'(out_valid[k]), 64'd0);
            check("midrst_digest", dg[k], CIV[k]);
            check("midrst_count", 64'(bc[k]), 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) check("midrst_release_ready", 64'(in_ready[k]), 64'd1);
        run_msg(2, 3, 2);
        run_msg(4, 3, 2);

        // Random messages with random stalls across widths and round counts.
        run_msg(0, $urandom_range(1, 40), 3);
        run_msg(1, $urandom_range(1, 40), 3);
        for (int j = 0; j < 2; j++) begin
            run_msg(2, $urandom_range(1, 300), 3);
            run_msg(3, $urandom_range(1, 300), 3);
            run_msg(4, $urandom_range(1, 300), 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
